// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Sequencing controller for the 5-stage pipeline. It turns the run enable,
//   load-use hazards, ID-stage branch resolution and the data-memory
//   handshake into PC / IF/ID / ID/EX / back-end enable, flush and bubble
//   controls. It also keeps saturating performance counters.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   start_i               run enable (level)
//   idex_memread_i        MemRead of the instruction in EX
//   idex_rd_i             rd of the instruction in EX
//   ifid_rs1_i/rs2_i      source registers of the instruction in ID
//   branch_taken_i        branch in ID resolved taken
//   exmem_memreq_i        instruction in MEM accesses data memory
//   dmem_ack_i            data memory completes the current access
//   pc_write_o            PC write enable
//   ifid_write_o          IF/ID write enable
//   ifid_flush_o          IF/ID clear to NOP
//   idex_bubble_o         zero control bits entering ID/EX
//   pipe_en_o             ID/EX, EX/MEM, MEM/WB write enable
//   dmem_req_o            data memory request
//   stall_o / flush_o     load-use stall / branch flush this cycle
//   err_o                 sticky memory-timeout error
//   stall_cnt_o, flush_cnt_o, memwait_cnt_o   saturating counters
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             idex_memread_i,
  input  logic [4:0]       idex_rd_i,
  input  logic [4:0]       ifid_rs1_i,
  input  logic [4:0]       ifid_rs2_i,
  input  logic             branch_taken_i,
  input  logic             exmem_memreq_i,
  input  logic             dmem_ack_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             pipe_en_o,
  output logic             dmem_req_o,
  output logic             stall_o,
  output logic             flush_o,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [CNT_W-1:0] memwait_cnt_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    ERR      = 2'd3
  } state_t;

  localparam logic [7:0] TIMEOUT_LIM = 8'(MEM_TIMEOUT);

  state_t     state_reg, state_next;
  logic [7:0] wait_reg, wait_next;
  logic       err_reg, err_next;
  logic       hazard;
  logic       memwait_inc;

  // Load-use: EX holds a load whose destination feeds ID (x0 never hazards).
  assign hazard = idex_memread_i && (idex_rd_i != 5'd0) &&
                  ((idex_rd_i == ifid_rs1_i) || (idex_rd_i == ifid_rs2_i));

  always_comb begin
    pc_write_o    = 1'b0;
    ifid_write_o  = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    pipe_en_o     = 1'b0;
    dmem_req_o    = 1'b0;
    stall_o       = 1'b0;
    flush_o       = 1'b0;
    memwait_inc   = 1'b0;
    state_next    = state_reg;
    wait_next     = wait_reg;

    case (state_reg)
      IDLE: begin
        if (start_i) state_next = RUN;
      end

      RUN: begin
        pc_write_o   = 1'b1;
        ifid_write_o = 1'b1;
        pipe_en_o    = 1'b1;
        dmem_req_o   = exmem_memreq_i;
        wait_next    = 8'd0;
        if (exmem_memreq_i && !dmem_ack_i) begin
          // Access not satisfied this cycle: freeze everything and wait.
          // The in-flight access takes precedence over a stop request.
          pc_write_o   = 1'b0;
          ifid_write_o = 1'b0;
          pipe_en_o    = 1'b0;
          memwait_inc  = 1'b1;
          state_next   = MEM_WAIT;
        end else begin
          if (hazard) begin
            // Branch operands are stale under a load-use hazard, so the
            // branch is re-evaluated after the bubble.
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_bubble_o = 1'b1;
            stall_o       = 1'b1;
          end else if (branch_taken_i) begin
            ifid_flush_o = 1'b1;
            flush_o      = 1'b1;
          end
          if (!start_i) state_next = IDLE;
        end
      end

      MEM_WAIT: begin
        dmem_req_o = 1'b1;
        if (dmem_ack_i) begin
          // Ack cycle retires the access; hazard/flush are not evaluated.
          pc_write_o   = 1'b1;
          ifid_write_o = 1'b1;
          pipe_en_o    = 1'b1;
          wait_next    = 8'd0;
          state_next   = RUN;
        end else begin
          memwait_inc = 1'b1;
          wait_next   = wait_reg + 8'd1;
          if (wait_next >= TIMEOUT_LIM) state_next = ERR;
        end
      end

      ERR: begin
        state_next = ERR;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign err_next = err_reg || (state_next == ERR);
  assign err_o    = err_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      wait_reg  <= 8'd0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      wait_reg  <= wait_next;
      err_reg   <= err_next;
    end
  end

  // Three identical saturating counters: 0 stall, 1 flush, 2 memory wait.
  logic [2:0]       cnt_inc;
  logic [CNT_W-1:0] cnt_reg [3];

  assign cnt_inc = {memwait_inc, flush_o, stall_o};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          cnt_reg[gi] <= '0;
        end else if (cnt_inc[gi] && (cnt_reg[gi] != {CNT_W{1'b1}})) begin
          cnt_reg[gi] <= cnt_reg[gi] + CNT_W'(1);
        end
      end
    end
  endgenerate

  assign stall_cnt_o   = cnt_reg[0];
  assign flush_cnt_o   = cnt_reg[1];
  assign memwait_cnt_o = cnt_reg[2];

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//   Self-checking bench for pipe_hazard_ctrl (CNT_W=4 so saturation is
//   reachable, MEM_TIMEOUT=16). Each driven cycle pushes its expected control
//   vector {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_en, dmem_req,
//   stall, flush, err} to a scoreboard queue; a checker popping on the
//   falling edge compares it with the DUT. Counters are checked inline.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 4;

  localparam logic [8:0] E_IDLE   = 9'b000000000;
  localparam logic [8:0] E_RUN    = 9'b110010000;
  localparam logic [8:0] E_STALL  = 9'b000110100;
  localparam logic [8:0] E_STALLQ = 9'b000111100; // stall during zero-wait access
  localparam logic [8:0] E_FLUSH  = 9'b111010010;
  localparam logic [8:0] E_FREEZE = 9'b000001000;
  localparam logic [8:0] E_ACK    = 9'b110011000;
  localparam logic [8:0] E_ERR    = 9'b000000001;

  logic clk = 1'b0;
  logic rst, start, memread, br, memreq, ack;
  logic [4:0] rd, rs1, rs2;
  logic pc_write, ifid_write, ifid_flush, idex_bubble, pipe_en, dmem_req;
  logic stall, flush, err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt, memwait_cnt;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic [8:0] exp;
    string      tag;
  } sb_item_t;

  sb_item_t sb_q[$];

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(16)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .start_i        (start),
    .idex_memread_i (memread),
    .idex_rd_i      (rd),
    .ifid_rs1_i     (rs1),
    .ifid_rs2_i     (rs2),
    .branch_taken_i (br),
    .exmem_memreq_i (memreq),
    .dmem_ack_i     (ack),
    .pc_write_o     (pc_write),
    .ifid_write_o   (ifid_write),
    .ifid_flush_o   (ifid_flush),
    .idex_bubble_o  (idex_bubble),
    .pipe_en_o      (pipe_en),
    .dmem_req_o     (dmem_req),
    .stall_o        (stall),
    .flush_o        (flush),
    .err_o          (err),
    .stall_cnt_o    (stall_cnt),
    .flush_cnt_o    (flush_cnt),
    .memwait_cnt_o  (memwait_cnt)
  );

  task automatic clr_in();
    memread = 1'b0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
    br = 1'b0; memreq = 1'b0; ack = 1'b0;
  endtask

  // One driven cycle: record the expectation, then advance past the edge.
  task automatic cyc(input logic [8:0] exp, input string tag);
    sb_item_t it;
    it.exp = exp;
    it.tag = tag;
    sb_q.push_back(it);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr_in();
    start = 1'b0;
    rst   = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic enter_run();
    start = 1'b1;
    cyc(E_IDLE, "idle_start");
  endtask

  task automatic test_reset();
    clr_in();
    start = 1'b0;
    rst   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tests_run++;
    if (err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_err got=%b exp=0", err);
    end
    tests_run++;
    if ({stall_cnt, flush_cnt, memwait_cnt} !== '0) begin
      tests_failed++;
      $display("FAIL reset_cnt got=%0d/%0d/%0d exp=0/0/0", stall_cnt, flush_cnt, memwait_cnt);
    end
    cyc(E_IDLE, "idle_hold");
    cyc(E_IDLE, "idle_hold2");
    $display("[TB] test_reset done");
  endtask

  task automatic test_run_normal();
    do_reset();
    enter_run();
    repeat (10) cyc(E_RUN, "run_normal");
    tests_run++;
    if ({stall_cnt, flush_cnt, memwait_cnt} !== '0) begin
      tests_failed++;
      $display("FAIL run_cnt got=%0d/%0d/%0d exp=0/0/0", stall_cnt, flush_cnt, memwait_cnt);
    end
    $display("[TB] test_run_normal done");
  endtask

  task automatic test_load_use();
    do_reset();
    enter_run();
    memread = 1'b1; rd = 5'd5; rs1 = 5'd3; rs2 = 5'd5;
    cyc(E_STALL, "lu_rs2");
    clr_in();
    cyc(E_RUN, "lu_clear");
    tests_run++;
    if (stall_cnt !== 4'd1) begin
      tests_failed++;
      $display("FAIL lu_cnt1 got=%0d exp=1", stall_cnt);
    end
    memread = 1'b1; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
    cyc(E_RUN, "lu_x0");
    memread = 1'b1; rd = 5'd7; rs1 = 5'd7; rs2 = 5'd2;
    cyc(E_STALL, "lu_rs1");
    memread = 1'b0;
    cyc(E_RUN, "lu_no_memread");
    tests_run++;
    if (stall_cnt !== 4'd2) begin
      tests_failed++;
      $display("FAIL lu_cnt2 got=%0d exp=2", stall_cnt);
    end
    $display("[TB] test_load_use done");
  endtask

  task automatic test_flush();
    do_reset();
    enter_run();
    br = 1'b1;
    cyc(E_FLUSH, "flush");
    br = 1'b0;
    cyc(E_RUN, "flush_clear");
    tests_run++;
    if (flush_cnt !== 4'd1) begin
      tests_failed++;
      $display("FAIL flush_cnt1 got=%0d exp=1", flush_cnt);
    end
    br = 1'b1; memread = 1'b1; rd = 5'd4; rs1 = 5'd4;
    cyc(E_STALL, "flush_vs_hazard");
    clr_in();
    cyc(E_RUN, "flush_clear2");
    tests_run++;
    if ({flush_cnt, stall_cnt} !== {4'd1, 4'd1}) begin
      tests_failed++;
      $display("FAIL flush_hazard_cnt got=%0d/%0d exp=1/1", flush_cnt, stall_cnt);
    end
    $display("[TB] test_flush done");
  endtask

  task automatic test_mem_wait();
    do_reset();
    enter_run();
    memreq = 1'b1; ack = 1'b0;
    cyc(E_FREEZE, "mem_req");
    cyc(E_FREEZE, "mem_wait1");
    start = 1'b0;                 // ignored while waiting
    cyc(E_FREEZE, "mem_wait2");
    start = 1'b1;
    ack = 1'b1; br = 1'b1;        // branch ignored in the ack cycle
    cyc(E_ACK, "mem_ack");
    clr_in();
    cyc(E_RUN, "mem_back_run");
    tests_run++;
    if ({memwait_cnt, flush_cnt} !== {4'd3, 4'd0}) begin
      tests_failed++;
      $display("FAIL memwait_cnt got=%0d flush=%0d exp=3/0", memwait_cnt, flush_cnt);
    end
    memreq = 1'b1; ack = 1'b1; memread = 1'b1; rd = 5'd6; rs1 = 5'd6;
    cyc(E_STALLQ, "zero_wait_hazard");
    clr_in();
    cyc(E_RUN, "zero_wait_done");
    tests_run++;
    if ({memwait_cnt, stall_cnt} !== {4'd3, 4'd1}) begin
      tests_failed++;
      $display("FAIL zero_wait_cnt got=%0d/%0d exp=3/1", memwait_cnt, stall_cnt);
    end
    start = 1'b0;
    cyc(E_RUN, "stop_req");
    cyc(E_IDLE, "idle_after_stop");
    $display("[TB] test_mem_wait done");
  endtask

  task automatic test_timeout();
    do_reset();
    enter_run();
    memreq = 1'b1; ack = 1'b0;
    repeat (17) cyc(E_FREEZE, "to_wait");
    ack = 1'b1;
    repeat (3) cyc(E_ERR, "to_err");
    tests_run++;
    if (err !== 1'b1) begin
      tests_failed++;
      $display("FAIL to_err_sticky got=%b exp=1", err);
    end
    tests_run++;
    if (memwait_cnt !== 4'd15) begin
      tests_failed++;
      $display("FAIL to_memwait_sat got=%0d exp=15", memwait_cnt);
    end
    do_reset();
    tests_run++;
    if ({err, memwait_cnt} !== 5'd0) begin
      tests_failed++;
      $display("FAIL to_rst_clear got err=%b mw=%0d exp=0/0", err, memwait_cnt);
    end
    cyc(E_IDLE, "to_idle");
    $display("[TB] test_timeout done");
  endtask

  task automatic test_saturation();
    do_reset();
    enter_run();
    memread = 1'b1; rd = 5'd5; rs1 = 5'd5;
    repeat (20) cyc(E_STALL, "sat_stall");
    clr_in();
    tests_run++;
    if (stall_cnt !== 4'd15) begin
      tests_failed++;
      $display("FAIL stall_sat got=%0d exp=15", stall_cnt);
    end
    $display("[TB] test_saturation done");
  endtask

  task automatic test_reset_mid();
    do_reset();
    enter_run();
    br = 1'b1;
    cyc(E_FLUSH, "mid_flush");
    clr_in();
    memreq = 1'b1;
    cyc(E_FREEZE, "mid_req");
    cyc(E_FREEZE, "mid_wait");
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b0; clr_in();
    tests_run++;
    if ({err, stall_cnt, flush_cnt, memwait_cnt} !== '0) begin
      tests_failed++;
      $display("FAIL mid_rst_cnt got=%0d/%0d/%0d err=%b exp=0", stall_cnt, flush_cnt, memwait_cnt, err);
    end
    memreq = 1'b1; ack = 1'b1;
    cyc(E_IDLE, "mid_rst_idle");
    clr_in();
    $display("[TB] test_reset_mid done");
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    clr_in();

    fork
      forever begin
        sb_item_t it;
        logic [8:0] act;
        @(negedge clk);
        if (sb_q.size() != 0) begin
          it  = sb_q.pop_front();
          act = {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_en,
                 dmem_req, stall, flush, err};
          tests_run++;
          if (act !== it.exp) begin
            tests_failed++;
            $display("FAIL %s got=%b exp=%b t=%0t", it.tag, act, it.exp, $time);
          end else begin
            $display("[TB] %s ctrl=%b ok", it.tag, act);
          end
        end
      end
    join_none

    test_reset();
    test_run_normal();
    test_load_use();
    test_flush();
    test_mem_wait();
    test_timeout();
    test_saturation();
    test_reset_mid();

    @(posedge clk);
    tests_run++;
    if (sb_q.size() != 0) begin
      tests_failed++;
      $display("FAIL sb_drain got=%0d exp=0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
